exmem_pipe: RTL and testbench
=============================

// Module: exmem_pipe
// PURPOSE
// - Execute->Memory pipeline register; feeds mwpipe (its *_M outputs drive mwpipe *_M inputs).
// - Holds the NZCV flags register and evaluates each instruction's 4-bit condition code.
// - Squashes failed instructions by clearing their control bits; supports stall (hold) and flush (bubble).
// PARAMETERS
// - DATA_W   32  ALU result / store-data width
// - REG_W    4   register specifier width
// - CNT_W    16  squash counter width (used only with EXMEM_SQUASH_CNT_EN)
// PORTS
// - clk          in   1       rising-edge clock
// - rst          in   1       reset, synchronous, active-low
// - stall        in   1       1 = hold all state this cycle
// - flush        in   1       1 = insert bubble into M this cycle
// - valid_E      in   1       E-stage instruction is real
// - pcload_E     in   1       instruction writes PC
// - regw_E       in   1       instruction writes register file
// - memw_E       in   1       instruction writes data memory
// - regmem_E     in   1       writeback selects memory data
// - setflags_E   in   1       instruction updates NZCV
// - cond_E       in   4       condition code
// - aluFlags_E   in   4       ALU flags {N,Z,C,V}
// - regScr_E     in   REG_W   destination register
// - ALUrslt_E    in   DATA_W  ALU result
// - wdata_E      in   DATA_W  store data
// - pcload_M, regw_M, memw_M, regmem_M  out 1 each  gated controls to M
// - regScr_M     out  REG_W   registered regScr_E
// - ALUrslt_M    out  DATA_W  registered ALUrslt_E
// - wdata_M      out  DATA_W  registered wdata_E
// - valid_M      out  1       M holds a real, condition-passed instruction
// - flags        out  4       architectural NZCV register {N,Z,C,V}
// - squash_cnt   out  CNT_W   only with EXMEM_SQUASH_CNT_EN
// BEHAVIOUR
// - Reset (rst==0 at posedge): every output and flags = 0; squash_cnt = 0.
// - Priority at each posedge: reset > flush > stall > load.
// - condpass is combinational from cond_E and the current flags register:
//   0000 Z, 0001 !Z, 0010 C, 0011 !C, 0100 N, 0101 !N, 0110 V, 0111 !V,
//   1000 C&!Z, 1001 !C|Z, 1010 N==V, 1011 N!=V, 1100 !Z&(N==V), 1101 Z|(N!=V), 1110 always, 1111 never.
// - exec = valid_E & condpass.
// - Load (no flush, no stall), latency 1 cycle:
//   - valid_M <= exec.
//   - pcload_M/regw_M/memw_M/regmem_M <= corresponding _E bit & exec.
//   - regScr_M, ALUrslt_M, wdata_M <= _E values unconditionally.
//   - flags <= aluFlags_E iff exec & setflags_E, else hold.
// - Stall: every register holds, including flags and squash_cnt; E inputs are ignored.
// - Flush: valid_M and all four control outputs <= 0; data outputs <= 0.
//   - Flags are not updated; flush overrides a simultaneous stall.
// - Back-to-back instructions: the 2nd instruction's condition sees the flags written by the 1st.
//   - The flag update is visible on the cycle after the 1st loads; there is no same-cycle bypass.
// - valid_E==0: treated as a bubble (all controls 0, valid_M 0); not counted as a squash.
// CONFIGURATION
// - EXMEM_SQUASH_CNT_EN defined:
//   - squash_cnt increments on each load cycle with valid_E & !condpass.
//   - Saturates at all-ones; it does not count during stall, flush or reset.
// - Not defined: the squash_cnt port and counter are absent; all other behaviour is identical.
// TESTING
// - Reset: hold rst=0 two cycles with random inputs -> all outputs 0, flags 4'b0000.
// - Pass-through: valid_E=1, cond_E=1110, regw_E=1, regScr_E=4'h3, ALUrslt_E=32'h0000FFFF
//   -> next cycle regw_M=1, regScr_M=3, ALUrslt_M=32'h0000FFFF, valid_M=1.
// - Flag chain: cycle0 setflags_E=1, aluFlags_E=4'b0100 (Z); cycle1 cond_E=0000 regw_E=1
//   -> flags=0100 and regw_M=1. Repeat with cond_E=0001 -> regw_M=0, valid_M=0, flags unchanged.
// - Stall: load a value, then stall=1 for 3 cycles with changing inputs
//   -> all outputs hold the first values; release -> new values appear 1 cycle later.
// - Flush vs stall: stall=1 and flush=1 with memw_E=1
//   -> memw_M=0, valid_M=0, ALUrslt_M=0, flags unchanged.
// - Macro on: 5 instructions with cond_E=1111, then 1 flush cycle -> squash_cnt=5.
//   Preload squash_cnt near all-ones -> it saturates at 16'hFFFF.

Source files
------------

// File: rtl/exmem_pipe_if.sv
// Execute->Memory bundle: E-stage inputs and gated M-stage outputs.
// The master side produces the E fields; exmem_pipe uses the slave side.
interface exmem_pipe_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
);
   logic              valid_E;
   logic              pcload_E;
   logic              regw_E;
   logic              memw_E;
   logic              regmem_E;
   logic              setflags_E;
   logic [3:0]        cond_E;
   logic [3:0]        aluFlags_E;
   logic [REG_W-1:0]  regScr_E;
   logic [DATA_W-1:0] ALUrslt_E;
   logic [DATA_W-1:0] wdata_E;

   logic              pcload_M;
   logic              regw_M;
   logic              memw_M;
   logic              regmem_M;
   logic              valid_M;
   logic [REG_W-1:0]  regScr_M;
   logic [DATA_W-1:0] ALUrslt_M;
   logic [DATA_W-1:0] wdata_M;

   modport master (
      output valid_E, pcload_E, regw_E, memw_E, regmem_E,
      output setflags_E, cond_E, aluFlags_E,
      output regScr_E, ALUrslt_E, wdata_E,
      input  pcload_M, regw_M, memw_M, regmem_M, valid_M,
      input  regScr_M, ALUrslt_M, wdata_M
   );

   modport slave (
      input  valid_E, pcload_E, regw_E, memw_E, regmem_E,
      input  setflags_E, cond_E, aluFlags_E,
      input  regScr_E, ALUrslt_E, wdata_E,
      output pcload_M, regw_M, memw_M, regmem_M, valid_M,
      output regScr_M, ALUrslt_M, wdata_M
   );
endinterface

// File: rtl/exmem_pipe.sv
// Execute->Memory pipeline register with NZCV flags and condition squash.
// Define EXMEM_SQUASH_CNT_EN to add the saturating squash_cnt output.
module exmem_pipe #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 4
`ifdef EXMEM_SQUASH_CNT_EN
   ,
   parameter int CNT_W  = 16
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       stall,
   input  logic       flush,
   exmem_pipe_if.slave bus,
`ifdef EXMEM_SQUASH_CNT_EN
   output logic [CNT_W-1:0] squash_cnt,
`endif
   output logic [3:0] flags
);

   logic              valid_q,  valid_d;
   logic              pcload_q, pcload_d;
   logic              regw_q,   regw_d;
   logic              memw_q,   memw_d;
   logic              regmem_q, regmem_d;
   logic [REG_W-1:0]  rs_q,     rs_d;
   logic [DATA_W-1:0] alu_q,    alu_d;
   logic [DATA_W-1:0] wd_q,     wd_d;
   logic [3:0]        flags_q,  flags_d;

   logic cond_pass;
   logic exec;
   logic load;
   logic fn, fz, fc, fv;

   assign fn = flags_q[3];
   assign fz = flags_q[2];
   assign fc = flags_q[1];
   assign fv = flags_q[0];

   // Condition sees only the registered flags; no bypass from E.
   always_comb begin
      unique case (bus.cond_E)
         4'b0000: cond_pass = fz;
         4'b0001: cond_pass = !fz;
         4'b0010: cond_pass = fc;
         4'b0011: cond_pass = !fc;
         4'b0100: cond_pass = fn;
         4'b0101: cond_pass = !fn;
         4'b0110: cond_pass = fv;
         4'b0111: cond_pass = !fv;
         4'b1000: cond_pass = fc & !fz;
         4'b1001: cond_pass = !fc | fz;
         4'b1010: cond_pass = (fn == fv);
         4'b1011: cond_pass = (fn != fv);
         4'b1100: cond_pass = !fz & (fn == fv);
         4'b1101: cond_pass = fz | (fn != fv);
         4'b1110: cond_pass = 1'b1;
         4'b1111: cond_pass = 1'b0;
      endcase
   end

   assign exec = bus.valid_E & cond_pass;
   assign load = !flush & !stall;

   always_comb begin
      valid_d  = valid_q;
      pcload_d = pcload_q;
      regw_d   = regw_q;
      memw_d   = memw_q;
      regmem_d = regmem_q;
      rs_d     = rs_q;
      alu_d    = alu_q;
      wd_d     = wd_q;
      flags_d  = flags_q;
      if (flush) begin
         valid_d  = 1'b0;
         pcload_d = 1'b0;
         regw_d   = 1'b0;
         memw_d   = 1'b0;
         regmem_d = 1'b0;
         rs_d     = '0;
         alu_d    = '0;
         wd_d     = '0;
      end else if (load) begin
         valid_d  = exec;
         pcload_d = bus.pcload_E & exec;
         regw_d   = bus.regw_E & exec;
         memw_d   = bus.memw_E & exec;
         regmem_d = bus.regmem_E & exec;
         rs_d     = bus.regScr_E;
         alu_d    = bus.ALUrslt_E;
         wd_d     = bus.wdata_E;
         if (exec & bus.setflags_E)
            flags_d = bus.aluFlags_E;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         valid_q  <= 1'b0;
         pcload_q <= 1'b0;
         regw_q   <= 1'b0;
         memw_q   <= 1'b0;
         regmem_q <= 1'b0;
         rs_q     <= '0;
         alu_q    <= '0;
         wd_q     <= '0;
         flags_q  <= 4'b0000;
      end else begin
         valid_q  <= valid_d;
         pcload_q <= pcload_d;
         regw_q   <= regw_d;
         memw_q   <= memw_d;
         regmem_q <= regmem_d;
         rs_q     <= rs_d;
         alu_q    <= alu_d;
         wd_q     <= wd_d;
         flags_q  <= flags_d;
      end
   end

`ifdef EXMEM_SQUASH_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load && bus.valid_E && !cond_pass && cnt_q != '1)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign squash_cnt = cnt_q;
`endif

   assign bus.valid_M   = valid_q;
   assign bus.pcload_M  = pcload_q;
   assign bus.regw_M    = regw_q;
   assign bus.memw_M    = memw_q;
   assign bus.regmem_M  = regmem_q;
   assign bus.regScr_M  = rs_q;
   assign bus.ALUrslt_M = alu_q;
   assign bus.wdata_M   = wd_q;
   assign flags         = flags_q;

endmodule

// File: tb/tb_exmem_pipe.sv
// Scoreboarded bench for exmem_pipe; squash counter checks need
// EXMEM_SQUASH_CNT_EN defined at compile time.
module tb_exmem_pipe;

   logic clk;
   logic rst;
   logic stall;
   logic flush;
   logic [3:0] flags;
   logic [15:0] cnt_act;

   exmem_pipe_if #(.DATA_W(32), .REG_W(4)) bus ();

`ifdef EXMEM_SQUASH_CNT_EN
   logic [15:0] squash_cnt;
   exmem_pipe dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .bus(bus), .squash_cnt(squash_cnt), .flags(flags)
   );
   assign cnt_act = squash_cnt;
`else
   exmem_pipe dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .bus(bus), .flags(flags)
   );
   assign cnt_act = 16'h0;
`endif

   typedef struct packed {
      logic v, pc, rw, mw, rm;
      logic [3:0]  rs;
      logic [31:0] alu;
      logic [31:0] wd;
      logic [3:0]  fl;
      logic [15:0] cnt;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #20_000_000;
      $display("FAIL watchdog: time limit reached, required completion");
      $fatal(1, "timeout");
   end

   function automatic logic cp(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v, b;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: b = z;
         3'd1: b = cy;
         3'd2: b = n;
         3'd3: b = v;
         3'd4: b = cy & !z;
         3'd5: b = (n == v);
         3'd6: b = !z & (n == v);
         default: b = 1'b1;
      endcase
      return b ^ c[0];
   endfunction

   // Compare every M-stage snapshot against the model's queued entry.
   always @(negedge clk) begin
      exp_t e, a;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         a = {bus.valid_M, bus.pcload_M, bus.regw_M, bus.memw_M,
              bus.regmem_M, bus.regScr_M, bus.ALUrslt_M, bus.wdata_M,
              flags, cnt_act};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL m_stage: got %h expected %h", a, e);
         end
      end
   end

   task automatic step(input logic r, input logic s, input logic f);
      logic ex;
      rst = r; stall = s; flush = f;
      ex = bus.valid_E & cp(bus.cond_E, cur.fl);
      if (!r) begin
         cur = '0;
      end else if (f) begin
         cur.v = 0; cur.pc = 0; cur.rw = 0; cur.mw = 0; cur.rm = 0;
         cur.rs = 0; cur.alu = 0; cur.wd = 0;
      end else if (!s) begin
         cur.v  = ex;
         cur.pc = bus.pcload_E & ex;
         cur.rw = bus.regw_E & ex;
         cur.mw = bus.memw_E & ex;
         cur.rm = bus.regmem_E & ex;
         cur.rs = bus.regScr_E;
         cur.alu = bus.ALUrslt_E;
         cur.wd = bus.wdata_E;
         if (ex && bus.setflags_E) cur.fl = bus.aluFlags_E;
`ifdef EXMEM_SQUASH_CNT_EN
         if (bus.valid_E && !ex && cur.cnt != 16'hFFFF)
            cur.cnt = cur.cnt + 16'd1;
`endif
      end
      sb.push_back(cur);
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic rand_in();
      bus.valid_E    = 1'($urandom);
      bus.pcload_E   = 1'($urandom);
      bus.regw_E     = 1'($urandom);
      bus.memw_E     = 1'($urandom);
      bus.regmem_E   = 1'($urandom);
      bus.setflags_E = 1'($urandom);
      bus.cond_E     = 4'($urandom);
      bus.aluFlags_E = 4'($urandom);
      bus.regScr_E   = 4'($urandom);
      bus.ALUrslt_E  = $urandom;
      bus.wdata_E    = $urandom;
   endtask

   task automatic clr_in();
      bus.valid_E = 0; bus.pcload_E = 0; bus.regw_E = 0;
      bus.memw_E = 0; bus.regmem_E = 0; bus.setflags_E = 0;
      bus.cond_E = 4'b1110; bus.aluFlags_E = 0;
      bus.regScr_E = 0; bus.ALUrslt_E = 0; bus.wdata_E = 0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         rand_in();
         step(1'b0, 1'($urandom), 1'($urandom));
      end
      checks++;
      if (flags !== 4'b0000 || bus.valid_M !== 1'b0) begin
         errors++;
         $display("FAIL reset: flags=%b valid_M=%b, required 0000/0",
                  flags, bus.valid_M);
      end
   endtask

   task automatic test_pass_through();
      clr_in();
      bus.valid_E = 1; bus.regw_E = 1;
      bus.regScr_E = 4'h3; bus.ALUrslt_E = 32'h0000FFFF;
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.regw_M !== 1'b1 || bus.regScr_M !== 4'h3 ||
          bus.ALUrslt_M !== 32'h0000FFFF || bus.valid_M !== 1'b1) begin
         errors++;
         $display("FAIL pass_through: regw=%b rs=%h alu=%h valid=%b, required 1 3 0000ffff 1",
                  bus.regw_M, bus.regScr_M, bus.ALUrslt_M, bus.valid_M);
      end
   endtask

   task automatic test_flag_chain();
      clr_in();
      bus.valid_E = 1; bus.setflags_E = 1; bus.aluFlags_E = 4'b0100;
      step(1'b1, 1'b0, 1'b0);
      clr_in();
      bus.valid_E = 1; bus.cond_E = 4'b0000; bus.regw_E = 1;
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (flags !== 4'b0100 || bus.regw_M !== 1'b1) begin
         errors++;
         $display("FAIL flag_chain_eq: flags=%b regw=%b, required 0100 1",
                  flags, bus.regw_M);
      end
      clr_in();
      bus.valid_E = 1; bus.cond_E = 4'b0001; bus.regw_E = 1;
      bus.setflags_E = 1; bus.aluFlags_E = 4'b1111;
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (flags !== 4'b0100 || bus.regw_M !== 1'b0 || bus.valid_M !== 1'b0) begin
         errors++;
         $display("FAIL flag_chain_ne: flags=%b regw=%b valid=%b, required 0100 0 0",
                  flags, bus.regw_M, bus.valid_M);
      end
   endtask

   task automatic test_stall();
      clr_in();
      bus.valid_E = 1; bus.cond_E = 4'b1110; bus.memw_E = 1;
      bus.ALUrslt_E = 32'hA5A5_0001; bus.wdata_E = 32'h1234_5678;
      step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         rand_in();
         step(1'b1, 1'b1, 1'b0);
         checks++;
         if (bus.ALUrslt_M !== 32'hA5A5_0001 || bus.memw_M !== 1'b1) begin
            errors++;
            $display("FAIL stall_hold: alu=%h memw=%b, required a5a50001 1",
                     bus.ALUrslt_M, bus.memw_M);
         end
      end
      clr_in();
      bus.ALUrslt_E = 32'h0BAD_F00D;
      step(1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.ALUrslt_M !== 32'h0BAD_F00D) begin
         errors++;
         $display("FAIL stall_release: alu=%h, required 0badf00d",
                  bus.ALUrslt_M);
      end
   endtask

   task automatic test_flush_vs_stall();
      logic [3:0] f0;
      f0 = flags;
      clr_in();
      bus.valid_E = 1; bus.memw_E = 1; bus.setflags_E = 1;
      bus.aluFlags_E = ~f0; bus.ALUrslt_E = 32'hDEAD_BEEF;
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if (bus.memw_M !== 1'b0 || bus.valid_M !== 1'b0 ||
          bus.ALUrslt_M !== 32'h0 || flags !== f0) begin
         errors++;
         $display("FAIL flush_stall: memw=%b valid=%b alu=%h flags=%b, required 0 0 0 %b",
                  bus.memw_M, bus.valid_M, bus.ALUrslt_M, flags, f0);
      end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 60; i++) begin
         rand_in();
         bus.valid_E = ($urandom_range(0, 3) != 0);
         step(1'b1, ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 7) == 0));
      end
   endtask

`ifdef EXMEM_SQUASH_CNT_EN
   task automatic test_squash_cnt();
      clr_in();
      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         rand_in();
         bus.valid_E = 1; bus.cond_E = 4'b1111;
         step(1'b1, 1'b0, 1'b0);
      end
      rand_in();
      bus.valid_E = 1; bus.cond_E = 4'b1111;
      step(1'b1, 1'b0, 1'b1);
      checks++;
      if (squash_cnt !== 16'd5) begin
         errors++;
         $display("FAIL squash_cnt5: got %0d required 5", squash_cnt);
      end
      clr_in();
      bus.valid_E = 1; bus.cond_E = 4'b1111;
      for (int i = 0; i < 65535; i++) begin
         rand_in();
         bus.valid_E = 1; bus.cond_E = 4'b1111;
         step(1'b1, 1'b0, 1'b0);
      end
      checks++;
      if (squash_cnt !== 16'hFFFF) begin
         errors++;
         $display("FAIL squash_sat: got %h required ffff", squash_cnt);
      end
   endtask
`endif

   initial begin
      cur = '0;
      rst = 0; stall = 0; flush = 0;
      clr_in();
      test_reset();
      test_pass_through();
      test_flag_chain();
      test_stall();
      test_flush_vs_stall();
      test_back_to_back();
`ifdef EXMEM_SQUASH_CNT_EN
      test_squash_cnt();
`endif
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_drain: %0d entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
